// File: rtl/activation_grad.sv
// ReLU backward gate: stores a positive-input mask per forward vector in a FIFO
// and applies it, in forward order, to incoming gradient vectors.
`ifndef DATA_TYPE_SIZE
`define DATA_TYPE_SIZE 16
`endif

module activation_grad #(
  parameter int IN_SIZE = 16,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = `DATA_TYPE_SIZE
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           fwd_valid_i,
  output logic                           fwd_ready_o,
  input  logic [IN_SIZE*DATA_W-1:0]      fwd_data_i,
  input  logic                           grad_valid_i,
  output logic                           grad_ready_o,
  input  logic [IN_SIZE*DATA_W-1:0]      grad_data_i,
  output logic                           grad_valid_o,
  input  logic                           grad_ready_i,
  output logic [IN_SIZE*DATA_W-1:0]      grad_data_o,
  input  logic                           flush_i,
  output logic [$clog2(DEPTH):0]         count_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid/data hold until taken.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IN_SIZE-1:0]        mask_mem [DEPTH];
  logic [PW-1:0]             wptr_q;
  logic [PW-1:0]             rptr_q;
  logic [CW-1:0]             count_q;
  logic [IN_SIZE-1:0]        fwd_mask;
  logic [IN_SIZE*DATA_W-1:0] gated;
  logic                      push;
  logic                      pop;

  assign fwd_ready_o  = !rst_i && (count_q < CW'(DEPTH));
  // Flush blocks the pop so a gradient is never paired with a discarded mask.
  assign grad_ready_o = !rst_i && !flush_i && (count_q != '0) &&
                        (!grad_valid_o || grad_ready_i);
  assign push    = fwd_valid_i && fwd_ready_o;
  assign pop     = grad_valid_i && grad_ready_o;
  assign count_o = count_q;

  always_comb begin
    fwd_mask = '0;
    gated    = '0;
    for (int j = 0; j < IN_SIZE; j++) begin
      // Strictly positive: the ReLU derivative at zero is taken as zero.
      fwd_mask[j] = $signed(fwd_data_i[j*DATA_W +: DATA_W]) > 0;
      gated[j*DATA_W +: DATA_W] = mask_mem[rptr_q][j] ?
                                  grad_data_i[j*DATA_W +: DATA_W] : '0;
    end
  end

  // Mask storage is not reset; its contents are only read behind count_q.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mask_mem[wptr_q] <= fwd_mask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      grad_valid_o <= 1'b0;
      grad_data_o  <= '0;
    end else begin
      if (flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      if (pop) begin
        grad_data_o  <= gated;
        grad_valid_o <= 1'b1;
      end else if (grad_ready_i) begin
        grad_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_activation_grad.sv
// Directed bench for activation_grad: a queue-based mask model checked every
// cycle, plus literal expectations at the interesting points.
module tb_activation_grad;

  localparam int IN_SIZE = 4;
  localparam int DEPTH   = 4;
  localparam int DW      = 16;
  localparam int VW      = IN_SIZE * DW;

  logic          clk;
  logic          rst;
  logic          fwd_valid;
  logic          fwd_ready;
  logic [VW-1:0] fwd_data;
  logic          grad_valid_in;
  logic          grad_ready_out;
  logic [VW-1:0] grad_data_in;
  logic          grad_valid_out;
  logic          grad_ready_in;
  logic [VW-1:0] grad_data_out;
  logic          flush;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  activation_grad #(.IN_SIZE(IN_SIZE), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .fwd_valid_i(fwd_valid), .fwd_ready_o(fwd_ready), .fwd_data_i(fwd_data),
    .grad_valid_i(grad_valid_in), .grad_ready_o(grad_ready_out),
    .grad_data_i(grad_data_in),
    .grad_valid_o(grad_valid_out), .grad_ready_i(grad_ready_in),
    .grad_data_o(grad_data_out),
    .flush_i(flush), .count_o(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: stored masks in forward order and the expected output register
  logic [IN_SIZE-1:0] exp_q[$];
  logic               m_valid = 1'b0;
  logic [VW-1:0]      m_data  = '0;
  logic               model_init = 1'b0;

  always @(negedge clk) begin
    logic efr, egr, do_push, do_pop;
    logic [IN_SIZE-1:0] m, nm;
    efr = !rst && (exp_q.size() < DEPTH);
    egr = !rst && !flush && (exp_q.size() > 0) && (!m_valid || grad_ready_in);
    check("fwd_ready", VW'(fwd_ready), VW'(efr));
    check("grad_ready", VW'(grad_ready_out), VW'(egr));
    if (model_init) begin
      check("count", VW'(count), VW'(exp_q.size()));
      check("grad_valid", VW'(grad_valid_out), VW'(m_valid));
      check("grad_data", grad_data_out, m_data);
    end
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      model_init = 1'b1;
    end else begin
      do_push = fwd_valid && efr;
      do_pop  = grad_valid_in && egr;
      if (do_pop) begin
        m = exp_q.pop_front();
        for (int j = 0; j < IN_SIZE; j++)
          m_data[j*DW +: DW] = m[j] ? grad_data_in[j*DW +: DW] : 16'h0;
        m_valid = 1'b1;
      end else if (grad_ready_in) begin
        m_valid = 1'b0;
      end
      if (flush) begin
        exp_q.delete();
      end else if (do_push) begin
        for (int j = 0; j < IN_SIZE; j++)
          nm[j] = $signed(fwd_data[j*DW +: DW]) > 0;
        exp_q.push_back(nm);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic fv, input logic [VW-1:0] fd, input logic gv,
                       input logic [VW-1:0] gd, input logic gr, input logic fl);
    fwd_valid = fv; fwd_data = fd; grad_valid_in = gv; grad_data_in = gd;
    grad_ready_in = gr; flush = fl;
  endtask

  task automatic step(input logic fv, input logic [VW-1:0] fd, input logic gv,
                      input logic [VW-1:0] gd, input logic gr, input logic fl);
    drive(fv, fd, gv, gd, gr, fl);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic push(input logic [VW-1:0] fd);
    step(1'b1, fd, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic grad(input logic [VW-1:0] gd, input logic gr);
    step(1'b0, '0, 1'b1, gd, gr, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("fwd_ready_after_reset", VW'(fwd_ready), VW'(1));

    // basic gating
    push(pk(5, -3, 0, 1));
    check("basic_count_push", VW'(count), VW'(1));
    grad(pk(10, 20, 30, 40), 1'b1);
    check("basic_data", grad_data_out, pk(10, 0, 0, 40));
    check("basic_count_pop", VW'(count), VW'(0));
    idle();

    // ordering and wrap-around: 6 pushes, pops interleaved
    push(pk(1, -1, 1, -1));
    push(pk(-32768, 32767, 0, 2));
    step(1'b1, pk(0, 0, 3, 3), 1'b1, pk(-5, 6, -7, 8), 1'b1, 1'b0);
    check("wrap_data0", grad_data_out, pk(-5, 0, -7, 0));
    step(1'b1, pk(9, -9, -9, 9), 1'b1, pk(100, 200, 300, 400), 1'b1, 1'b0);
    check("wrap_data1", grad_data_out, pk(0, 200, 0, 400));
    step(1'b1, pk(-2, 4, -6, 8), 1'b1, pk(11, 22, 33, 44), 1'b1, 1'b0);
    step(1'b1, pk(7, 7, 7, 7), 1'b1, pk(-1, -2, -3, -4), 1'b1, 1'b0);
    grad(pk(50, 60, 70, 80), 1'b1);
    grad(pk(90, 91, 92, 93), 1'b1);
    check("wrap_data5", grad_data_out, pk(90, 91, 92, 93));
    idle();

    // full / empty
    for (int i = 0; i < DEPTH; i++) push(pk(i + 1, -i, i, -1));
    check("full_ready", VW'(fwd_ready), VW'(0));
    check("full_count", VW'(count), VW'(4));
    for (int i = 0; i < DEPTH; i++) grad(pk(3, 3, 3, 3), 1'b1);
    check("empty_ready", VW'(grad_ready_out), VW'(0));
    check("empty_count", VW'(count), VW'(0));
    idle();

    // backpressure
    push(pk(1, 1, -1, -1));
    push(pk(-1, 2, -2, 3));
    grad(pk(7, 8, 9, 10), 1'b1);
    for (int i = 0; i < 3; i++) begin
      grad(pk(11, 12, 13, 14), 1'b0);
      check("bp_valid", VW'(grad_valid_out), VW'(1));
      check("bp_data", grad_data_out, pk(7, 8, 0, 0));
    end
    grad(pk(11, 12, 13, 14), 1'b1);
    check("bp_release_data", grad_data_out, pk(0, 12, 0, 14));
    check("bp_release_count", VW'(count), VW'(0));
    idle();

    // simultaneous push/pop with one stored
    push(pk(4, 4, 4, 4));
    step(1'b1, pk(-4, 4, -4, 4), 1'b1, pk(1, 2, 3, 4), 1'b1, 1'b0);
    check("simul_count", VW'(count), VW'(1));
    grad(pk(5, 6, 7, 8), 1'b1);
    check("simul_data", grad_data_out, pk(0, 6, 0, 8));
    idle();

    // empty with same-cycle push: no bypass
    drive(1'b1, pk(1, 0, 1, 0), 1'b1, pk(21, 22, 23, 24), 1'b1, 1'b0);
    #1 check("nobypass_ready0", VW'(grad_ready_out), VW'(0));
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b1, pk(21, 22, 23, 24), 1'b1, 1'b0);
    #1 check("nobypass_ready1", VW'(grad_ready_out), VW'(1));
    @(posedge clk); #1;
    check("nobypass_data", grad_data_out, pk(21, 0, 23, 0));
    idle();

    // flush while holding an output, with a discarded push
    for (int i = 0; i < DEPTH; i++) push(pk(1, 1, 1, 1));
    grad(pk(31, 32, 33, 34), 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, pk(1, 1, 1, 1), 1'b1, pk(9, 9, 9, 9), 1'b0, 1'b1);
    check("flush_count", VW'(count), VW'(0));
    check("flush_valid", VW'(grad_valid_out), VW'(1));
    check("flush_data", grad_data_out, pk(31, 32, 33, 34));
    idle();
    push(pk(-1, -1, 5, 5));
    grad(pk(41, 42, 43, 44), 1'b1);
    check("postflush_data", grad_data_out, pk(0, 0, 43, 44));
    idle();

    // reset mid-transfer
    push(pk(2, 2, 2, 2));
    push(pk(3, 3, 3, 3));
    grad(pk(51, 52, 53, 54), 1'b1);
    rst = 1'b1;
    drive(1'b1, pk(1, 1, 1, 1), 1'b1, pk(1, 1, 1, 1), 1'b0, 1'b0);
    #1 check("rst_fwd_ready", VW'(fwd_ready), VW'(0));
    check("rst_grad_ready", VW'(grad_ready_out), VW'(0));
    @(posedge clk); #1;
    check("rst_valid", VW'(grad_valid_out), VW'(0));
    check("rst_data", grad_data_out, '0);
    check("rst_count", VW'(count), VW'(0));
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    #1 check("rst_release_fwd_ready", VW'(fwd_ready), VW'(1));
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
